ram_block_engine: RTL and testbench

RAM_BLOCK_ENGINE -- requirements
Module: ram_block_engine

---
 rtl/ram_block_engine.sv | 149 ++++++++++++++
 tb/tb_ram_block_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_block_engine.sv
// ram_block_engine: single-port RAM command engine (COPY / FILL / SUM).
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   start, op       - command request (sampled only when not busy) and opcode
//   src, dst, len   - source/destination start addresses, word count (0..2^ADDR_W)
//   fill_val        - FILL pattern
//   busy, done, err - command in progress, one-cycle completion pulse, last command rejected
//   sum             - SUM result, held until the next accepted start
//   mem_addr, mem_we, mem_data, mem_q - RAM port (read data valid one cycle after address)
//
// FIN is the done cycle. It is idle in every observable way: busy=0, mem_* idle and a new
// start is accepted exactly as in IDLE.
module ram_block_engine #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       sum,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [1:0]      OpCopy = 2'd0;
    localparam logic [1:0]      OpFill = 2'd1;
    localparam logic [1:0]      OpSum  = 2'd2;
    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] One    = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, RD, WR, CAP, FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [ADDR_W:0]     len_q;
    logic [DATA_W-1:0]   fill_q;
    logic                err_q;
    logic [15:0]         sum_q;

    logic accept, illegal, last, capture;

    assign accept  = start && (state_q == IDLE || state_q == FIN);
    assign illegal = (op == 2'd3) || (len > MaxLen);
    assign last    = (idx_q == len_q - One);
    // Read data for word idx-1 arrives while word idx is addressed, and in CAP for the last.
    assign capture = (op_q == OpSum) &&
                     ((state_q == RD && idx_q != '0) || state_q == CAP);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                idx_d   = '0;
                if (start) begin
                    if (illegal || len == '0) begin
                        state_d = FIN;
                    end else if (op == OpFill) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (op_q == OpCopy) begin
                    state_d = WR;
                end else if (last) begin
                    state_d = CAP;
                end else begin
                    idx_d = idx_q + One;
                end
            end
            WR: begin
                if (last) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + One;
                    state_d = (op_q == OpCopy) ? RD : WR;
                end
            end
            CAP:     state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_data = '0;
        case (state_q)
            RD: mem_addr = src_q + idx_q[ADDR_W-1:0];
            WR: begin
                mem_addr = dst_q + idx_q[ADDR_W-1:0];
                mem_we   = 1'b1;
                mem_data = (op_q == OpFill) ? fill_q : mem_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                op_q   <= op;
                src_q  <= src;
                dst_q  <= dst;
                len_q  <= len;
                fill_q <= fill_val;
                err_q  <= illegal;
                sum_q  <= '0;
            end else if (capture) begin
                sum_q <= sum_q + 16'(mem_q);
            end
        end
    end

    assign busy = (state_q != IDLE) && (state_q != FIN);
    assign done = (state_q == FIN);
    assign err  = err_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_ram_block_engine.sv
// Directed bench for ram_block_engine with a behavioural single-port RAM.
module tb_ram_block_engine;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [1:0]    op;
    logic [AW-1:0] src, dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill_val;
    logic          busy, done, err;
    logic [15:0]   sum;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] ram [64];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    ram_block_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst), .len(len),
        .fill_val(fill_val), .busy(busy), .done(done), .err(err), .sum(sum),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: q updates only on read cycles, held during writes.
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_data;
        else mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int a, input int d);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = DW'(d);
        step();
        ld_en = 1'b0;
    endtask

    // Leaves the bench in cycle 1 of the accepted command.
    task automatic issue(input int o, input int s, input int d, input int l, input int f,
                         input bit hold);
        op = 2'(o); src = AW'(s); dst = AW'(d); len = (AW+1)'(l); fill_val = DW'(f);
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc, input int exp_wr);
        int c = 1;
        int w = 0;
        while (!done && c < 200) begin
            if (mem_we) w++;
            step();
            c++;
        end
        check({tag, "_done_cycle"}, c, exp_cyc);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_writes"}, w, exp_wr);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; src = '0; dst = '0; len = '0; fill_val = '0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sum", sum, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 64; i++) ld(i, 0);
        ld(10, 11); ld(11, 22); ld(12, 33); ld(13, 44);

        // COPY 10 -> 40, len 4
        issue(0, 10, 40, 4, 0, 1'b0);
        check("copy_c1_busy", busy, 1);
        check("copy_c1_addr", mem_addr, 10);
        check("copy_c1_we", mem_we, 0);
        wait_done("copy", 9, 4);
        check("copy_r40", ram[40], 11);
        check("copy_r41", ram[41], 22);
        check("copy_r42", ram[42], 33);
        check("copy_r43", ram[43], 44);

        // FILL wrapping past the top of the address space
        issue(1, 0, 62, 4, 'hA5, 1'b0);
        check("fill_c1_addr", mem_addr, 62);
        check("fill_c1_we", mem_we, 1);
        check("fill_c1_data", mem_data, 'hA5);
        wait_done("fill", 5, 4);
        check("fill_r62", ram[62], 'hA5);
        check("fill_r63", ram[63], 'hA5);
        check("fill_r0", ram[0], 'hA5);
        check("fill_r1", ram[1], 'hA5);
        check("fill_r61", ram[61], 0);
        check("fill_r2", ram[2], 0);

        // SUM of 11+22+33+44
        issue(2, 10, 0, 4, 0, 1'b0);
        wait_done("sum4", 6, 0);
        check("sum4_val", sum, 110);

        // Illegal opcode, then oversize length, then a legal len=0 clearing err
        issue(3, 0, 0, 4, 0, 1'b0);
        wait_done("op3", 1, 0);
        check("op3_err", err, 1);
        check("op3_sum_cleared", sum, 0);
        step();
        check("op3_err_held", err, 1);
        check("op3_done_pulse", done, 0);
        issue(0, 0, 0, 65, 0, 1'b0);
        wait_done("len65", 1, 0);
        check("len65_err", err, 1);
        issue(2, 0, 0, 0, 0, 1'b0);
        wait_done("len0", 1, 0);
        check("len0_err", err, 0);
        check("len0_sum", sum, 0);

        // Overlapping COPY 10 -> 11: ascending order propagates ram[10]
        issue(0, 10, 11, 3, 0, 1'b0);
        wait_done("ovl", 7, 3);
        check("ovl_r11", ram[11], 11);
        check("ovl_r12", ram[12], 11);
        check("ovl_r13", ram[13], 11);

        // Reset in cycle 5 of COPY 0 -> 20, len 8
        issue(0, 0, 20, 8, 0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_we", mem_we, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (done || mem_we) seen++;
                step();
            end
            check("abort_no_activity", seen, 0);
        end
        check("abort_r20", ram[20], 'hA5);
        check("abort_r21", ram[21], 'hA5);
        check("abort_r22", ram[22], 0);

        // start held high: second command taken in the done cycle of the first
        issue(0, 10, 30, 2, 0, 1'b1);
        op = 2'd1; dst = 6'd50; len = 7'd1; fill_val = 8'h3C;
        wait_done("held1", 5, 2);
        step();
        start = 1'b0;
        check("held2_busy", busy, 1);
        check("held2_addr", mem_addr, 50);
        check("held2_we", mem_we, 1);
        wait_done("held2", 2, 1);
        check("held_r30", ram[30], 11);
        check("held_r31", ram[31], 11);
        check("held_r50", ram[50], 'h3C);

        // Full-memory SUM of 0xFF
        for (int i = 0; i < 64; i++) ld(i, 'hFF);
        issue(2, 0, 0, 64, 0, 1'b0);
        wait_done("sum64", 66, 0);
        check("sum64_val", sum, 16320);
        step(); step();
        check("sum64_held", sum, 16320);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
